alu_multicycle: RTL and testbench

//  Multi-cycle companion to the single-cycle alu. Handles the long operations: full-width

---
 rtl/alu_multicycle_pkg.sv | 54 +++++
 rtl/alu_multicycle_if.sv | 33 +++
 rtl/alu_multicycle_barrel_shifter.sv | 58 +++++
 rtl/alu_multicycle.sv | 254 +++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_multicycle_pkg.sv
// Shared types for the multi-cycle ALU: op encoding, FSM states
// and small op-class decode helpers used by the datapath.
package alu_multicycle_pkg;

    localparam int MC_WIDTH = 32;

    typedef enum logic [3:0] {
        MC_MULU  = 4'd0,
        MC_MULS  = 4'd1,
        MC_MULHU = 4'd2,
        MC_MULHS = 4'd3,
        MC_DIVU  = 4'd4,
        MC_DIVS  = 4'd5,
        MC_REMU  = 4'd6,
        MC_REMS  = 4'd7,
        MC_LSL   = 4'd8,
        MC_LSR   = 4'd9,
        MC_ASR   = 4'd10,
        MC_ROL   = 4'd11,
        MC_ROR   = 4'd12
    } t_alu_mc_op;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIXUP,
        ST_DONE
    } t_mc_state;

    function automatic logic mc_is_mul(input t_alu_mc_op op);
        return op inside {MC_MULU, MC_MULS, MC_MULHU, MC_MULHS};
    endfunction

    function automatic logic mc_is_div(input t_alu_mc_op op);
        return op inside {MC_DIVU, MC_DIVS, MC_REMU, MC_REMS};
    endfunction

    function automatic logic mc_is_shift(input t_alu_mc_op op);
        return op inside {MC_LSL, MC_LSR, MC_ASR, MC_ROL, MC_ROR};
    endfunction

    function automatic logic mc_is_signed(input t_alu_mc_op op);
        return op inside {MC_MULS, MC_MULHS, MC_DIVS, MC_REMS};
    endfunction

    function automatic logic mc_is_high(input t_alu_mc_op op);
        return op inside {MC_MULHU, MC_MULHS};
    endfunction

    function automatic logic mc_is_quot(input t_alu_mc_op op);
        return op inside {MC_DIVU, MC_DIVS};
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Issue/result bundle between the control unit (master) and the
// multi-cycle ALU (slave): start/abort/op/operands in; busy/done/result/flags out.
interface alu_multicycle_if #(
    parameter int WIDTH = alu_multicycle_pkg::MC_WIDTH
);
    import alu_multicycle_pkg::*;

    logic             start;
    logic             abort;
    t_alu_mc_op       op;
    logic [WIDTH-1:0] reg2;
    logic [WIDTH-1:0] reg3;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero_out;
    logic             neg_out;
    logic             over_out;

    modport master (
        output start, abort, op, reg2, reg3,
        input  busy, done, result,
        input  carry_out, zero_out, neg_out, over_out
    );

    modport slave (
        input  start, abort, op, reg2, reg3,
        output busy, done, result,
        output carry_out, zero_out, neg_out, over_out
    );

endinterface

// File: rtl/alu_multicycle_barrel_shifter.sv
// Combinational shifter/rotator (LSL, LSR, ASR, ROL, ROR).
// Ports: i_op mode, i_src data, i_amt amount; o_result, o_carry (last bit out).
module alu_multicycle_barrel_shifter
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH      = MC_WIDTH,
    parameter int SHAMT_BITS = $clog2(WIDTH)
) (
    input  t_alu_mc_op            i_op,
    input  logic [WIDTH-1:0]      i_src,
    input  logic [SHAMT_BITS-1:0] i_amt,
    output logic [WIDTH-1:0]      o_result,
    output logic                  o_carry
);

    // WIDTH - amt; equals WIDTH for amt=0 so the rotate
    // back-shift drops out cleanly.
    logic [SHAMT_BITS:0]   w_inv;
    logic [SHAMT_BITS-1:0] w_lsl_idx;
    logic [SHAMT_BITS-1:0] w_rsh_idx;

    assign w_inv     = (SHAMT_BITS+1)'(WIDTH) - {1'b0, i_amt};
    assign w_lsl_idx = w_inv[SHAMT_BITS-1:0];
    assign w_rsh_idx = i_amt - SHAMT_BITS'(1);

    always_comb begin
        o_result = i_src;
        o_carry  = 1'b0;
        case (i_op)
            MC_LSL: begin
                o_result = i_src << i_amt;
                o_carry  = i_src[w_lsl_idx];
            end
            MC_LSR: begin
                o_result = i_src >> i_amt;
                o_carry  = i_src[w_rsh_idx];
            end
            MC_ASR: begin
                o_result = $signed(i_src) >>> i_amt;
                o_carry  = i_src[w_rsh_idx];
            end
            MC_ROL: begin
                o_result = (i_src << i_amt) | (i_src >> w_inv);
                o_carry  = o_result[0];
            end
            MC_ROR: begin
                o_result = (i_src >> i_amt) | (i_src << w_inv);
                o_carry  = o_result[WIDTH-1];
            end
            default: ;
        endcase
        if (i_amt == '0) begin
            o_result = i_src;
            o_carry  = 1'b0;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: radix-2 multiply/divide on magnitudes with sign fixup,
// plus single-cycle shifts and divide special cases.
// Ports: i_clock, i_reset (async, active-low), io_bus (slave modport).
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = MC_WIDTH
) (
    input  logic            i_clock,
    input  logic            i_reset,
    alu_multicycle_if.slave io_bus
);

    localparam int SHAMT_BITS = $clog2(WIDTH);
    localparam int CNT_BITS   = SHAMT_BITS + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    t_mc_state            r_state;
    t_mc_state            w_next_state;
    t_alu_mc_op           r_op;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;
    logic [CNT_BITS-1:0]  r_cnt;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic [WIDTH-1:0]     r_result;
    logic                 r_carry;
    logic                 r_zero;
    logic                 r_neg;
    logic                 r_over;

    logic                 w_accept;
    logic                 w_busy;
    logic                 w_done;

    // Issue-side decode of the operands on the bus.
    t_alu_mc_op           w_op;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_div0;
    logic                 w_div_ovf;
    logic                 w_fast;

    assign w_op    = io_bus.op;
    assign w_a     = io_bus.reg2;
    assign w_b     = io_bus.reg3;
    assign w_a_neg = mc_is_signed(w_op) & w_a[WIDTH-1];
    assign w_b_neg = mc_is_signed(w_op) & w_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~w_a + 1'b1) : w_a;
    assign w_b_mag = w_b_neg ? (~w_b + 1'b1) : w_b;

    assign w_div0    = mc_is_div(w_op) && (w_b == '0);
    assign w_div_ovf = mc_is_div(w_op) && mc_is_signed(w_op)
                    && (w_a == MOST_NEG) && (w_b == '1);

    // Anything that is not a regular mul/div completes in one
    // cycle; unused op codes complete with a zero result.
    assign w_fast = !(mc_is_mul(w_op) || mc_is_div(w_op))
                 || w_div0 || w_div_ovf;

    logic [WIDTH-1:0] w_sh_result;
    logic             w_sh_carry;

    alu_multicycle_barrel_shifter #(
        .WIDTH      (WIDTH),
        .SHAMT_BITS (SHAMT_BITS)
    ) u_shifter (
        .i_op     (w_op),
        .i_src    (w_a),
        .i_amt    (w_b[SHAMT_BITS-1:0]),
        .o_result (w_sh_result),
        .o_carry  (w_sh_carry)
    );

    logic [WIDTH-1:0] w_fast_res;
    logic             w_fast_carry;
    logic             w_fast_over;

    always_comb begin
        w_fast_res   = '0;
        w_fast_carry = 1'b0;
        w_fast_over  = 1'b0;
        if (w_div0) begin
            w_fast_res  = mc_is_quot(w_op) ? '1 : w_a;
            w_fast_over = 1'b1;
        end else if (w_div_ovf) begin
            w_fast_res  = mc_is_quot(w_op) ? w_a : '0;
            w_fast_over = 1'b1;
        end else if (mc_is_shift(w_op)) begin
            w_fast_res   = w_sh_result;
            w_fast_carry = w_sh_carry;
        end
    end

    // One radix-2 step on the shared accumulator.
    // Mul: {hi,lo} = {partial, multiplier}, add multiplicand then shift right.
    // Div: {hi,lo} = {remainder, dividend/quotient}, restoring shift-subtract.
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_acc_step;

    assign {w_hi, w_lo} = r_acc;
    assign w_mul_sum = {1'b0, w_hi}
                     + (w_lo[0] ? {1'b0, r_opb} : '0);
    assign w_trial   = {w_hi, w_lo[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, r_opb};

    always_comb begin
        w_acc_step = r_acc;
        if (mc_is_mul(r_op)) begin
            w_acc_step = {w_mul_sum, w_lo[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            w_acc_step = {w_diff[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_step = {w_trial[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fixup of the magnitude result.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_slow_res;
    logic               w_slow_flag;

    assign w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quot = r_neg_res ? (~w_lo + 1'b1) : w_lo;
    assign w_rem  = r_neg_rem ? (~w_hi + 1'b1) : w_hi;

    always_comb begin
        w_slow_res  = '0;
        w_slow_flag = 1'b0;
        if (mc_is_mul(r_op)) begin
            if (mc_is_high(r_op)) begin
                w_slow_res = w_prod[2*WIDTH-1:WIDTH];
            end else begin
                w_slow_res = w_prod[WIDTH-1:0];
                if (mc_is_signed(r_op)) begin
                    w_slow_flag = w_prod[2*WIDTH-1:WIDTH]
                               != {WIDTH{w_prod[WIDTH-1]}};
                end else begin
                    w_slow_flag = w_prod[2*WIDTH-1:WIDTH] != '0;
                end
            end
        end else begin
            w_slow_res = mc_is_quot(r_op) ? w_quot : w_rem;
        end
    end

    // Result load: fast ops at the accepting edge, mul/div on
    // leaving FIXUP. Both land in DONE.
    logic             w_load_fast;
    logic             w_load_slow;
    logic [WIDTH-1:0] w_ld_res;
    logic             w_ld_carry;
    logic             w_ld_over;

    assign w_load_fast = w_accept && w_fast;
    assign w_load_slow = (r_state == ST_FIXUP) && !io_bus.abort;
    assign w_ld_res    = w_load_fast ? w_fast_res   : w_slow_res;
    assign w_ld_carry  = w_load_fast ? w_fast_carry : w_slow_flag;
    assign w_ld_over   = w_load_fast ? w_fast_over  : w_slow_flag;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_busy       = (r_state != ST_IDLE);
        w_done       = (r_state == ST_DONE);
        unique case (r_state)
            ST_IDLE: begin
                if (io_bus.start && !io_bus.abort) begin
                    w_accept     = 1'b1;
                    w_next_state = w_fast ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (io_bus.abort) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == CNT_BITS'(1)) begin
                    w_next_state = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                w_next_state = io_bus.abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_op      <= MC_MULU;
            r_acc     <= '0;
            r_opb     <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_over    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= w_op;
                r_cnt     <= CNT_BITS'(WIDTH);
                r_acc     <= {{WIDTH{1'b0}},
                              mc_is_mul(w_op) ? w_b_mag : w_a_mag};
                r_opb     <= mc_is_mul(w_op) ? w_a_mag : w_b_mag;
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
            end else if (r_state == ST_RUN) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt - CNT_BITS'(1);
            end
            if (w_load_fast || w_load_slow) begin
                r_result <= w_ld_res;
                r_carry  <= w_ld_carry;
                r_over   <= w_ld_over;
                r_zero   <= (w_ld_res == '0);
                r_neg    <= w_ld_res[WIDTH-1];
            end
        end
    end

    assign io_bus.busy      = w_busy;
    assign io_bus.done      = w_done;
    assign io_bus.result    = r_result;
    assign io_bus.carry_out = r_carry;
    assign io_bus.zero_out  = r_zero;
    assign io_bus.neg_out   = r_neg;
    assign io_bus.over_out  = r_over;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed cases,
// abort/busy/reset scenarios and random ops against a 64-bit arithmetic model.
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] last_res;
    logic [3:0]  last_flg;

    alu_multicycle_if #(.WIDTH(32)) bus ();

    alu_multicycle #(.WIDTH(32)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; flags {carry,zero,neg,over}.
    function automatic void model(input t_alu_mc_op op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r,
                                  output logic [3:0] f,
                                  output int lat);
        logic [63:0] p;
        logic [63:0] t;
        longint sa;
        longint sb;
        logic c;
        logic o;
        int amt;
        c   = 1'b0;
        o   = 1'b0;
        r   = '0;
        lat = 1;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        amt = int'(b[4:0]);
        case (op)
            MC_MULU, MC_MULHU, MC_MULS, MC_MULHS: begin
                lat = 34;
                if (op == MC_MULU || op == MC_MULHU)
                    p = 64'(a) * 64'(b);
                else
                    p = 64'(sa * sb);
                if (op == MC_MULHU || op == MC_MULHS) begin
                    r = p[63:32];
                end else begin
                    r = p[31:0];
                    if (op == MC_MULU) c = (p[63:32] != 0);
                    else c = (p[63:32] != {32{p[31]}});
                    o = c;
                end
            end
            MC_DIVU, MC_REMU, MC_DIVS, MC_REMS: begin
                if (b == 0) begin
                    r = (op == MC_DIVU || op == MC_DIVS) ? 32'hffffffff : a;
                    o = 1'b1;
                end else if ((op == MC_DIVS || op == MC_REMS)
                             && a == 32'h80000000 && b == 32'hffffffff) begin
                    r = (op == MC_DIVS) ? a : 32'h0;
                    o = 1'b1;
                end else begin
                    lat = 34;
                    case (op)
                        MC_DIVU: r = a / b;
                        MC_REMU: r = a % b;
                        MC_DIVS: r = 32'(sa / sb);
                        default: r = 32'(sa % sb);
                    endcase
                end
            end
            MC_LSL: begin
                t = 64'(a) << amt;
                r = t[31:0];
                c = t[32];
            end
            MC_LSR: begin
                t = {a, 32'h0} >> amt;
                r = t[63:32];
                c = t[31];
            end
            MC_ASR: begin
                t = 64'($signed({a, 32'h0}) >>> amt);
                r = t[63:32];
                c = t[31];
            end
            MC_ROL: begin
                t = {a, a} << amt;
                r = t[63:32];
                c = r[0];
            end
            MC_ROR: begin
                t = {a, a} >> amt;
                r = t[31:0];
                c = r[31];
            end
            default: ;
        endcase
        if (op >= MC_LSL && amt == 0) begin
            r = a;
            c = 1'b0;
        end
        f = {c, (r == 0), r[31], o};
    endfunction

    task automatic run_op(input string tag, input t_alu_mc_op op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic [3:0]  ef;
        int el;
        int n;
        model(op, a, b, er, ef, el);
        @(negedge clk);
        bus.op = op; bus.reg2 = a; bus.reg3 = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".res"}, bus.result, er);
        chk({tag, ".flg"}, {bus.carry_out, bus.zero_out,
                            bus.neg_out, bus.over_out}, ef);
        chk({tag, ".lat"}, n, el);
        @(posedge clk); #1;
        chk({tag, ".idle"}, {bus.busy, bus.done}, 2'b00);
        last_res = er;
        last_flg = ef;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hffffffff;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int n;
        logic seen;
        n_tests = 0;
        n_fail  = 0;
        last_res = '0;
        last_flg = '0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.op = MC_MULU;
        bus.reg2 = '0; bus.reg3 = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {bus.busy, bus.done, bus.result, bus.carry_out,
                      bus.zero_out, bus.neg_out, bus.over_out}, 0);
        @(negedge clk) rst_n = 1'b1;

        run_op("mulu_ff",  MC_MULU,  32'hffffffff, 32'hffffffff);
        run_op("mulhu_ff", MC_MULHU, 32'hffffffff, 32'hffffffff);
        run_op("muls_ff",  MC_MULS,  32'hffffffff, 32'hffffffff);
        run_op("muls_7f",  MC_MULS,  32'h00007fff, 32'h00008000);
        run_op("divs_m7",  MC_DIVS,  32'hfffffff9, 32'h00000002);
        run_op("rems_m7",  MC_REMS,  32'hfffffff9, 32'h00000002);
        run_op("divu_100", MC_DIVU,  32'h00000064, 32'h00000007);
        run_op("divu_0",   MC_DIVU,  32'h00000064, 32'h00000000);
        run_op("divs_ovf", MC_DIVS,  32'h80000000, 32'hffffffff);
        run_op("ror_1",    MC_ROR,   32'h00000001, 32'h00000001);
        run_op("asr_31",   MC_ASR,   32'h80000000, 32'h0000001f);
        run_op("lsl_21",   MC_LSL,   32'h80000001, 32'h00000021);

        // abort mid-RUN: no done, result/flags keep prior values
        @(negedge clk);
        bus.op = MC_MULU; bus.reg2 = 32'd5; bus.reg3 = 32'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort.busy", bus.busy, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        chk("abort.nodone", seen, 1'b0);
        chk("abort.res", bus.result, last_res);
        chk("abort.flg", {bus.carry_out, bus.zero_out,
                          bus.neg_out, bus.over_out}, last_flg);

        // start while busy is ignored
        @(negedge clk);
        bus.op = MC_DIVU; bus.reg2 = 32'd100; bus.reg3 = 32'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 1;
        repeat (4) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        bus.op = MC_LSL; bus.reg2 = 32'd1; bus.reg3 = 32'd1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n++;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_start.res", bus.result, 32'h0000000e);
        chk("busy_start.lat", n, 34);
        @(posedge clk); #1;

        // reset mid-RUN clears everything at once
        @(negedge clk);
        bus.op = MC_MULU; bus.reg2 = 32'hffffffff; bus.reg3 = 32'hffffffff;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("rst_run", {bus.busy, bus.done, bus.result, bus.carry_out,
                        bus.zero_out, bus.neg_out, bus.over_out}, 0);
        @(negedge clk) rst_n = 1'b1;
        last_res = '0;
        last_flg = '0;

        for (int i = 0; i < 60; i++) begin
            t_alu_mc_op rop;
            rop = t_alu_mc_op'(4'($urandom_range(0, 12)));
            run_op($sformatf("rnd%0d_%s", i, rop.name()), rop, pick(), pick());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
